// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard controller.
// Tag rd fields are held at FWD_RD_W bits; REG_AW must not exceed FWD_RD_W.
package fwd_pkg;

    localparam int FWD_RD_W   = 8;
    localparam int FWD_SEL_RF = 0;

    typedef logic [FWD_RD_W-1:0] fwd_rd_t;

    typedef struct packed {
        logic    valid;
        fwd_rd_t rd;
        logic    is_load;
    } fwd_tag_t;

    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request / EX bypass-select bundle between the decode stage and the hazard controller.
interface fwd_hazard_ctrl_if
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3
);
    localparam int SELW = sel_width(FWD_STAGES);

    logic                      id_valid_i;
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [NUM_SRC-1:0]        id_rs_used_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      id_regwrite_i;
    logic                      id_is_load_i;
    logic                      flush_i;
    logic                      stall_o;
    logic [NUM_SRC*SELW-1:0]   fwd_sel_o;

    modport master (
        output id_valid_i, id_rs_i, id_rs_used_i, id_rd_i,
        output id_regwrite_i, id_is_load_i, flush_i,
        input  stall_o, fwd_sel_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rs_used_i, id_rd_i,
        input  id_regwrite_i, id_is_load_i, flush_i,
        output stall_o, fwd_sel_o
    );

endinterface

// File: rtl/fwd_tag_pipe.sv
// In-flight destination tag shift register: slot 0 = EX, slots 1..FWD_STAGES beyond it.
// A bubble (all-zero tag) enters slot 0 whenever load_i is low.
module fwd_tag_pipe
    import fwd_pkg::*;
#(
    parameter int FWD_STAGES = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       load_i,
    input  fwd_tag_t                   tag_i,
    output fwd_tag_t [FWD_STAGES:0]    tags_o
);

    fwd_tag_t [FWD_STAGES:0] tags_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tags_q <= '0;
        end else begin
            tags_q[0] <= load_i ? tag_i : '0;
            for (int s = 1; s <= FWD_STAGES; s++) begin
                tags_q[s] <= tags_q[s-1];
            end
        end
    end

    assign tags_o = tags_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: per-source youngest-match bypass select and ID stall.
// Define FWD_STATS_EN to add stall_cnt_o / fwd_cnt_o statistics counters.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    fwd_hazard_ctrl_if.slave   bus
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        fwd_cnt_o
`endif
);

    localparam int SELW = sel_width(FWD_STAGES);

    fwd_tag_t [FWD_STAGES:0]  tags;
    fwd_tag_t                 id_tag;
    logic [NUM_SRC-1:0]       early_load;
    logic [NUM_SRC*SELW-1:0]  win_sel;
    logic [NUM_SRC*SELW-1:0]  fwd_sel_d, fwd_sel_q;
    logic                     stall, advance;

    assign id_tag = '{valid:   bus.id_regwrite_i,
                      rd:      fwd_rd_t'(bus.id_rd_i),
                      is_load: bus.id_is_load_i};

    fwd_tag_pipe #(.FWD_STAGES(FWD_STAGES)) u_tag_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (advance),
        .tag_i   (id_tag),
        .tags_o  (tags)
    );

    // Scan oldest to youngest so the youngest match is the last one written.
    // A match in the last slot retires this cycle, so its value comes from the regfile.
    always_comb begin
        win_sel    = '0;
        early_load = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int p = FWD_STAGES; p >= 0; p--) begin
                if (tags[p].valid && (tags[p].rd != '0) && bus.id_rs_used_i[k] &&
                    (tags[p].rd == fwd_rd_t'(bus.id_rs_i[k*REG_AW +: REG_AW]))) begin
                    win_sel[k*SELW +: SELW] = (p == FWD_STAGES) ? SELW'(FWD_SEL_RF) : SELW'(p + 1);
                    early_load[k]           = tags[p].is_load && (p < LOAD_LAT);
                end
            end
        end
    end

    assign stall     = bus.id_valid_i && !bus.flush_i && (|early_load);
    assign advance   = bus.id_valid_i && !bus.flush_i && !stall;
    assign fwd_sel_d = advance ? win_sel : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fwd_sel_q <= '0;
        end else begin
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign bus.stall_o   = stall;
    assign bus.fwd_sel_o = fwd_sel_q;

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] fwd_cnt_d, fwd_cnt_q;

    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    assign fwd_cnt_d   = (advance && (|win_sel)) ? fwd_cnt_q + 32'd1 : fwd_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed hazard scenarios plus random traffic against an
// instruction-history model of the forwarding rules.
module tb_fwd_hazard_ctrl;

    localparam int NUM_SRC    = 2;
    localparam int REG_AW     = 5;
    localparam int FWD_STAGES = 3;
    localparam int LOAD_LAT   = 1;
    localparam int SELW       = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) bus ();

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    fwd_hazard_ctrl #(
        .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt_o (stall_cnt),
        .fwd_cnt_o   (fwd_cnt)
`endif
    );

    // Model: most recent instruction that entered EX is hist[0]; age = cycles since.
    typedef struct { bit wr; int rd; bit ld; } ent_t;
    ent_t hist[$];

    int n_chk  = 0;
    int n_fail = 0;
    int exp_stall_cnt = 0;
    int exp_fwd_cnt   = 0;
    logic last_stall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] sel_of(input int k);
        logic [NUM_SRC*SELW-1:0] v;
        v = bus.fwd_sel_o;
        return 32'(v[k*SELW +: SELW]);
    endfunction

    function automatic int find_age(input int rs, input bit used);
        if (!used || rs == 0) return -1;
        for (int a = 0; a < hist.size() && a < FWD_STAGES; a++)
            if (hist[a].wr && hist[a].rd == rs) return a;
        return -1;
    endfunction

    // One ID cycle: drive, check the stall, clock, check the resulting selects.
    task automatic cyc(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                       input int rd, input bit rw, input bit ld, input bit fl);
        int a[NUM_SRC];
        int esel[NUM_SRC];
        bit any, exp_stall, adv;
        bus.id_valid_i    = v;
        bus.id_rs_i       = {5'(rs1), 5'(rs0)};
        bus.id_rs_used_i  = used;
        bus.id_rd_i       = 5'(rd);
        bus.id_regwrite_i = rw;
        bus.id_is_load_i  = ld;
        bus.flush_i       = fl;
        #1;
        a[0] = find_age(rs0, used[0]);
        a[1] = find_age(rs1, used[1]);
        any = 0;
        for (int k = 0; k < NUM_SRC; k++)
            if (a[k] >= 0 && hist[a[k]].ld && a[k] < LOAD_LAT) any = 1;
        exp_stall  = v && !fl && any;
        adv        = v && !fl && !exp_stall;
        last_stall = bus.stall_o;
        check_eq("stall", 32'(bus.stall_o), 32'(exp_stall));
        for (int k = 0; k < NUM_SRC; k++) esel[k] = (adv && a[k] >= 0) ? a[k] + 1 : 0;
        @(posedge clk);
        hist.push_front('{wr: adv && rw, rd: rd, ld: ld});
        if (hist.size() > FWD_STAGES + 1) void'(hist.pop_back());
        if (exp_stall) exp_stall_cnt++;
        if (adv && (esel[0] != 0 || esel[1] != 0)) exp_fwd_cnt++;
        #1;
        for (int k = 0; k < NUM_SRC; k++) check_eq($sformatf("sel%0d", k), sel_of(k), 32'(esel[k]));
`ifdef FWD_STATS_EN
        check_eq("stall_cnt", stall_cnt, 32'(exp_stall_cnt));
        check_eq("fwd_cnt", fwd_cnt, 32'(exp_fwd_cnt));
`endif
        @(negedge clk);
    endtask

    initial begin
        bus.id_valid_i = 0; bus.id_rs_i = '0; bus.id_rs_used_i = '0; bus.id_rd_i = '0;
        bus.id_regwrite_i = 0; bus.id_is_load_i = 0; bus.flush_i = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_stall", 32'(bus.stall_o), 32'd0);
        check_eq("rst_sel", 32'(bus.fwd_sel_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD x5 then a reader of x5: no stall, EX/MEM bypass
        cyc(1, 0, 0, 2'b00, 5, 1, 0, 0);
        cyc(1, 5, 0, 2'b01, 0, 0, 0, 0);
        check_eq("t1_stall", 32'(last_stall), 32'd0);
        check_eq("t1_sel0", sel_of(0), 32'd1);

        // LW x7 then a reader of x7 on src1: one stall cycle, then slot 2
        cyc(1, 0, 0, 2'b00, 7, 1, 1, 0);
        cyc(1, 0, 7, 2'b10, 0, 0, 0, 0);
        check_eq("t2_stall", 32'(last_stall), 32'd1);
        cyc(1, 0, 7, 2'b10, 0, 0, 0, 0);
        check_eq("t2_stall_end", 32'(last_stall), 32'd0);
        check_eq("t2_sel1", sel_of(1), 32'd2);

        // x3 written twice; the younger copy wins
        cyc(1, 0, 0, 2'b00, 3, 1, 0, 0);
        cyc(1, 0, 0, 2'b00, 3, 1, 0, 0);
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0);
        cyc(1, 3, 0, 2'b01, 0, 0, 0, 0);
        check_eq("t3_sel0", sel_of(0), 32'd2);

        // x0 never forwards; unused source never forwards
        cyc(1, 0, 0, 2'b00, 0, 1, 0, 0);
        cyc(1, 0, 0, 2'b01, 0, 0, 0, 0);
        check_eq("t4_x0_sel", sel_of(0), 32'd0);
        cyc(1, 0, 0, 2'b00, 4, 1, 0, 0);
        cyc(1, 4, 0, 2'b00, 0, 0, 0, 0);
        check_eq("t4_unused_sel", sel_of(0), 32'd0);

        // Load-use with flush in the same cycle: flush wins
        cyc(1, 0, 0, 2'b00, 9, 1, 1, 0);
        cyc(1, 9, 0, 2'b01, 0, 0, 0, 1);
        check_eq("t5_stall", 32'(last_stall), 32'd0);
        check_eq("t5_sel0", sel_of(0), 32'd0);

        // Async reset with live tags and a pending stall
        cyc(1, 0, 0, 2'b00, 5, 1, 0, 0);
        cyc(1, 5, 0, 2'b01, 7, 1, 1, 0);
        bus.id_valid_i = 1; bus.id_rs_i = {5'd7, 5'd0}; bus.id_rs_used_i = 2'b10; bus.flush_i = 0;
        #1;
        check_eq("t6_pre_stall", 32'(bus.stall_o), 32'd1);
        check_eq("t6_pre_sel0", sel_of(0), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_stall", 32'(bus.stall_o), 32'd0);
        check_eq("t6_sel", 32'(bus.fwd_sel_o), 32'd0);
        hist.delete();
        exp_stall_cnt = 0;
        exp_fwd_cnt   = 0;
`ifdef FWD_STATS_EN
        check_eq("t6_stall_cnt", stall_cnt, 32'd0);
        check_eq("t6_fwd_cnt", fwd_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic over a small register set to force frequent hazards
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom_range(0, 3)), $urandom_range(0, 3),
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
